// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared definitions for the decoder round-robin arbiter.
//   SEL_W  : select width driven to the 3-to-8 decoder
//   N_REQ  : number of requesters (one per decoder output)
//   arb_state_e : arbiter FSM states
// Helpers compute the wrapped successor index and an "all except one" mask.
package decoder_arb_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned N_REQ = 1 << SEL_W;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Successor index; wraps N_REQ-1 -> 0 through natural overflow.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
    return i + SEL_W'(1);
  endfunction

  // Mask with every requester enabled except index i.
  function automatic logic [N_REQ-1:0] all_but(input logic [SEL_W-1:0] i);
    return ~(N_REQ'(1) << i);
  endfunction

endpackage

// File: rtl/decoder_rr_arbiter_pick.sv
// Combinational round-robin picker.
// Ports:
//   req   in  N_REQ  request vector
//   mask  in  N_REQ  requesters eligible for this search
//   start in  SEL_W  first index examined; search wraps modulo N_REQ
//   found out 1      some bit of req & mask is set
//   idx   out SEL_W  first set bit of req & mask at or after start
module rr_pick
  import decoder_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] masked;
  logic [SEL_W-1:0] cand;

  assign masked = req & mask;

  // Linear scan from start; the SEL_W-bit add wraps the index for free.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = start + SEL_W'(k);
      if (!found && masked[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoded resource among 8 requesters.
// sel/en drive the decoder directly, so its one-hot output is the grant vector.
// Ownership is bounded to MAX_HOLD consecutive cycles; when the limit is hit
// and nobody else is waiting, the same owner is re-granted with a fresh pulse.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high
//   req          in   level request per requester, bit k = requester k
//   sel          out  current owner index (decoder select)
//   en           out  grant active (decoder enable)
//   grant_start  out  one-cycle pulse on the first cycle of every grant
module decoder_rr_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             grant_start
);

  localparam int unsigned          HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [SEL_W-1:0]  sel_q,   sel_d;
  logic              en_q,    en_d;
  logic              gs_q,    gs_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  logic [SEL_W-1:0]  last_q,  last_d;

  logic [N_REQ-1:0]  pick_mask;
  logic [SEL_W-1:0]  pick_start;
  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;
  logic              keep;

  // One picker serves both searches: from IDLE every requester is eligible
  // starting after the last owner; from GRANT the current owner is masked out
  // so the picker answers "is anyone else waiting".
  always_comb begin
    if (state_q == GRANT) begin
      pick_mask  = all_but(sel_q);
      pick_start = next_idx(sel_q);
    end else begin
      pick_mask  = '1;
      pick_start = next_idx(last_q);
    end
  end

  rr_pick u_pick (
    .req   (req),
    .mask  (pick_mask),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign keep = req[sel_q] && (hold_q < HOLD_LAST);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    gs_d    = 1'b0;
    hold_d  = hold_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          en_d    = 1'b1;
          gs_d    = 1'b1;
          hold_d  = '0;
          last_d  = pick_idx;
        end
      end
      GRANT: begin
        if (keep) begin
          hold_d = hold_q + HOLD_W'(1);
        end else if (pick_found) begin
          sel_d  = pick_idx;
          gs_d   = 1'b1;
          hold_d = '0;
          last_d = pick_idx;
        end else if (req[sel_q]) begin
          gs_d   = 1'b1;
          hold_d = '0;
        end else begin
          state_d = IDLE;
          en_d    = 1'b0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      gs_q    <= 1'b0;
      hold_q  <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      gs_q    <= gs_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign sel         = sel_q;
  assign en          = en_q;
  assign grant_start = gs_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter (MAX_HOLD = 4): directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_decoder_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [2:0] sel;
  logic       en;
  logic       grant_start;

  int vectors     = 0;
  int miscompares = 0;

  decoder_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .sel         (sel),
    .en          (en),
    .grant_start (grant_start)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [2:0] m_sel;
  logic       m_en;
  logic       m_gs;
  int         m_last;
  int         m_run;     // cycles the current ownership has been held
  bit         m_valid = 1'b0;

  // First requester at from+1, from+2, ... (mod 8), skipping excl; -1 if none.
  function automatic int search(input int from, input logic [7:0] r, input int excl);
    int c;
    for (int k = 1; k <= 8; k++) begin
      c = (from + k) % 8;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int p;
    if (rst) begin
      m_sel = 3'd0; m_en = 1'b0; m_gs = 1'b0; m_last = 7; m_run = 0;
    end else if (!m_en) begin
      p = search(m_last, req, -1);
      m_gs = 1'b0;
      if (p >= 0) begin
        m_en = 1'b1; m_sel = 3'(p); m_last = p; m_gs = 1'b1; m_run = 1;
      end
    end else if (req[m_sel] && m_run < MAX_HOLD) begin
      m_run = m_run + 1; m_gs = 1'b0;
    end else begin
      p = search(int'(m_sel), req, int'(m_sel));
      if (p >= 0) begin
        m_sel = 3'(p); m_last = p; m_gs = 1'b1; m_run = 1;
      end else if (req[m_sel]) begin
        m_gs = 1'b1; m_run = 1;
      end else begin
        m_en = 1'b0; m_gs = 1'b0; m_run = 0;
      end
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      vectors++;
      if (sel !== m_sel || en !== m_en || grant_start !== m_gs) begin
        miscompares++;
        $display("FAIL model t=%0t: got sel=%0d en=%b gs=%b, want sel=%0d en=%b gs=%b",
                 $time, sel, en, grant_start, m_sel, m_en, m_gs);
      end
      vectors++;
      if (en !== 1'b1 && grant_start !== 1'b0) begin
        miscompares++;
        $display("FAIL invariant t=%0t: got en=%b gs=%b, want gs=0 when en=0",
                 $time, en, grant_start);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int s, input bit e, input bit g);
    vectors++;
    if (sel !== 3'(s) || en !== e || grant_start !== g) begin
      miscompares++;
      $display("FAIL %s: got sel=%0d en=%b gs=%b, want sel=%0d en=%b gs=%b",
               name, sel, en, grant_start, s, e, g);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 8'hFF;

    // 1: reset held two cycles, then requester 0 wins
    step(); chk("rst_c1", 0, 0, 0);
    step(); chk("rst_c2", 0, 0, 0);
    rst = 1'b0;
    step(); chk("post_rst", 0, 1, 1);

    // 2: lone requester 3 re-granted every MAX_HOLD cycles
    req = 8'h08;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("solo3_c%0d", i), 3, 1, (i == 1 || i == 5 || i == 9));
    end

    // 3: two requesters alternate every MAX_HOLD cycles
    rst = 1'b1; req = 8'h81;
    step(); chk("rst_mid", 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("alt_c%0d", i), ((i / 4) % 2) ? 7 : 0, 1, (i % 4) == 0);
    end

    // 4: owner 6 drops, wrap to 0 with no gap
    req = 8'h41;
    step(); chk("own6_start", 6, 1, 1);
    step(); chk("own6_keep", 6, 1, 0);
    req = 8'h01;
    step(); chk("wrap_to0", 0, 1, 1);

    // 5: owner 2 drops with nothing pending, then search starts at 3
    req = 8'h04;
    step(); chk("own2", 2, 1, 1);
    req = 8'h00;
    step(); chk("idle", 2, 0, 0);
    req = 8'h30;
    step(); chk("from_idle4", 4, 1, 1);

    // 6: reset during a grant to 5 discards ownership and the pointer
    req = 8'h20;
    step(); chk("own5", 5, 1, 1);
    rst = 1'b1; req = 8'h06;
    step(); chk("rst_in_grant", 0, 0, 0);
    rst = 1'b0;
    step(); chk("ptr_reset", 1, 1, 1);

    // Mixed traffic checked by the model alone
    for (int i = 0; i < 200; i++) begin
      req = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 9) == 0) req = 8'h00;
      rst = ($urandom_range(0, 40) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
